wb_stage: RTL and testbench

Write-back stage of the five-stage MIPS pipeline: the M/W pipeline register plus write-data selection and load-data extension. It captures the memory-stage result each cycle and presents `w_pc`, `w_reg_addr` and `w_reg_data` directly to the D-stage register file's write port. It also exposes the same values as the W-level forwarding source. Bubbles are encoded as a write to `$0`, which the register file ignores.

---
 rtl/mips_pkg.sv | 17 +
 rtl/load_ext.sv | 34 +++
 rtl/wb_stage.sv | 88 ++++++++
 tb/tb_wb_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: write-data selects, load types and the reset PC.
package mips_pkg;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;
  localparam logic [1:0] WD_RSV = 2'd3;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extraction and extension from an aligned DM word.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    // off[0] is deliberately ignored for halfwords: misalignment is not trapped
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LD_LB:   ext_data = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  ext_data = {24'd0, byte_v};
      LD_LH:   ext_data = {{16{half_v[15]}}, half_v};
      LD_LHU:  ext_data = {16'd0, half_v};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// M/W pipeline register with write-data selection and load extension.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_reg_addr,
  input  logic [1:0]  m_wd_sel,
  input  logic [2:0]  m_load_type,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_mem_rdata,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0] w_retired,
`endif
  output logic        w_valid,
  output logic [31:0] w_pc,
  output logic [4:0]  w_reg_addr,
  output logic [31:0] w_reg_data
);

  // m_valid qualifies the M-stage fields; there is no ready: W accepts every cycle.
  logic        valid_q;
  logic [31:0] pc_q;
  logic [4:0]  addr_q;
  logic [1:0]  sel_q;
  logic [2:0]  load_type_q;
  logic [31:0] alu_q;
  logic [31:0] rdata_q;
  logic [31:0] ext_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= RESET_PC;
      addr_q      <= 5'd0;
      sel_q       <= WD_ALU;
      load_type_q <= LD_LW;
      alu_q       <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      valid_q     <= m_valid;
      pc_q        <= m_pc;
      addr_q      <= m_valid ? m_reg_addr : 5'd0;
      sel_q       <= m_wd_sel;
      load_type_q <= m_load_type;
      alu_q       <= m_alu_result;
      rdata_q     <= m_mem_rdata;
    end
  end

  load_ext u_load_ext (
    .rdata     (rdata_q),
    .off       (alu_q[1:0]),
    .load_type (load_type_q),
    .ext_data  (ext_data)
  );

  always_comb begin
    w_reg_data = 32'd0;
    case (sel_q)
      WD_ALU:  w_reg_data = alu_q;
      WD_MEM:  w_reg_data = ext_data;
      WD_PC8:  w_reg_data = pc_q + 32'd8;
      default: w_reg_data = 32'd0;
    endcase
  end

  assign w_valid    = valid_q;
  assign w_pc       = pc_q;
  assign w_reg_addr = (sel_q == WD_RSV) ? 5'd0 : addr_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) retired_q <= 32'd0;
    else if (m_valid) retired_q <= retired_q + 32'd1;
  end

  assign w_retired = retired_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors, a behavioural model with an
// expected queue compared every cycle, and literal spot checks.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [4:0]  m_reg_addr = 5'd0;
  logic [1:0]  m_wd_sel = 2'd0;
  logic [2:0]  m_load_type = 3'd0;
  logic [31:0] m_alu_result = 32'd0;
  logic [31:0] m_mem_rdata = 32'd0;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [4:0]  w_reg_addr;
  logic [31:0] w_reg_data;
  logic [31:0] w_retired_obs;

  int n_checks = 0;
  int n_fail = 0;

  // {valid, pc, addr, data, retired}
  localparam int W = 1 + 32 + 5 + 32 + 32;
  logic [W-1:0] exp_q[$];
  logic [31:0]  model_ret = 32'd0;

  wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .m_valid      (m_valid),
    .m_pc         (m_pc),
    .m_reg_addr   (m_reg_addr),
    .m_wd_sel     (m_wd_sel),
    .m_load_type  (m_load_type),
    .m_alu_result (m_alu_result),
    .m_mem_rdata  (m_mem_rdata),
`ifdef WB_RETIRE_CNT_EN
    .w_retired    (w_retired_obs),
`endif
    .w_valid      (w_valid),
    .w_pc         (w_pc),
    .w_reg_addr   (w_reg_addr),
    .w_reg_data   (w_reg_data)
  );

`ifndef WB_RETIRE_CNT_EN
  assign w_retired_obs = 32'd0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_data(input logic [1:0] sel, input logic [2:0] lt,
                                             input logic [31:0] pc, input logic [31:0] alu,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    case (sel)
      2'd0: return alu;
      2'd2: return pc + 32'd8;
      2'd1: begin
        case (lt)
          3'd1: begin sh = rdata >> (8 * alu[1:0]); return {{24{sh[7]}}, sh[7:0]}; end
          3'd2: begin sh = rdata >> (8 * alu[1:0]); return {24'd0, sh[7:0]}; end
          3'd3: begin sh = rdata >> (16 * alu[1]); return {{16{sh[15]}}, sh[15:0]}; end
          3'd4: begin sh = rdata >> (16 * alu[1]); return {16'd0, sh[15:0]}; end
          default: return rdata;
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  // Predicts what W shows after each edge, from the inputs present at that edge.
  always @(posedge clk) begin
    logic [31:0] nxt_ret;
    logic [4:0]  e_addr;
    nxt_ret = reset ? 32'd0 : model_ret + (m_valid ? 32'd1 : 32'd0);
    model_ret <= nxt_ret;
    if (reset) begin
      exp_q.push_back({1'b0, 32'h0000_3000, 5'd0, 32'd0, nxt_ret});
    end else begin
      e_addr = (m_valid && m_wd_sel != 2'd3) ? m_reg_addr : 5'd0;
      exp_q.push_back({m_valid, m_pc, e_addr,
                       model_data(m_wd_sel, m_load_type, m_pc, m_alu_result, m_mem_rdata),
                       nxt_ret});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_valid", {31'd0, w_valid}, {31'd0, e[W-1]});
      chk("sb_pc", w_pc, e[W-2 -: 32]);
      chk("sb_addr", {27'd0, w_reg_addr}, {27'd0, e[W-34 -: 5]});
      chk("sb_data", w_reg_data, e[63:32]);
`ifdef WB_RETIRE_CNT_EN
      chk("sb_retired", w_retired_obs, e[31:0]);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic v, input logic [31:0] pc, input logic [4:0] ra,
                      input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu,
                      input logic [31:0] rdata);
    reset = rst;
    m_valid = v;
    m_pc = pc;
    m_reg_addr = ra;
    m_wd_sel = sel;
    m_load_type = lt;
    m_alu_result = alu;
    m_mem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    // reset held two cycles
    step(1, 0, 32'h0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    step(1, 0, 32'h0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    chk("rst_pc", w_pc, 32'h0000_3000);
    chk("rst_addr", {27'd0, w_reg_addr}, 32'd0);
    chk("rst_data", w_reg_data, 32'd0);
    chk("rst_valid", {31'd0, w_valid}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retired", w_retired_obs, 32'd0);
`endif
    step(0, 0, 32'h0000_3000, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);

    // ALU write
    step(0, 1, 32'h0000_3004, 5'd8, 2'd0, 3'd0, 32'h1234_5678, 32'h0);
    chk("alu_addr", {27'd0, w_reg_addr}, 32'd8);
    chk("alu_data", w_reg_data, 32'h1234_5678);
    chk("alu_pc", w_pc, 32'h0000_3004);

    // loads
    step(0, 1, 32'h0000_3008, 5'd9, 2'd1, 3'd1, 32'h1000_0003, RD);
    chk("lb_off3", w_reg_data, 32'hFFFF_FF80);
    step(0, 1, 32'h0000_300C, 5'd9, 2'd1, 3'd2, 32'h1000_0003, RD);
    chk("lbu_off3", w_reg_data, 32'h0000_0080);
    step(0, 1, 32'h0000_3010, 5'd9, 2'd1, 3'd3, 32'h1000_0002, RD);
    chk("lh_off2", w_reg_data, 32'hFFFF_80FF);
    step(0, 1, 32'h0000_3014, 5'd9, 2'd1, 3'd4, 32'h1000_0001, RD);
    chk("lhu_off1", w_reg_data, 32'h0000_7F01);
    step(0, 1, 32'h0000_3018, 5'd9, 2'd1, 3'd0, 32'h1000_0002, RD);
    chk("lw", w_reg_data, 32'h80FF_7F01);
    // every load type at every offset, unlisted types act as LW
    for (int lt = 0; lt < 8; lt++)
      for (int off = 0; off < 4; off++)
        step(0, 1, 32'h0000_4000 + 32'(lt * 16 + off * 4), 5'(lt + 10), 2'd1, 3'(lt),
             32'h2000_0000 | 32'(off), 32'hC37A_51E6);

    // PC+8 (jal) including wrap
    step(0, 1, 32'h0000_3010, 5'd31, 2'd2, 3'd0, 32'hDEAD_BEEF, 32'h0);
    chk("pc8", w_reg_data, 32'h0000_3018);
    step(0, 1, 32'hFFFF_FFFC, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0);
    chk("pc8_wrap", w_reg_data, 32'h0000_0004);

    // reserved select: no write, data 0
    step(0, 1, 32'h0000_3020, 5'd10, 2'd3, 3'd0, 32'h5555_AAAA, RD);
    chk("rsv_addr", {27'd0, w_reg_addr}, 32'd0);
    chk("rsv_data", w_reg_data, 32'd0);

    // bubble between two writes, counted from a fresh reset
    step(1, 0, 32'h0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    step(0, 1, 32'h0000_3100, 5'd7, 2'd0, 3'd0, 32'h0000_0007, 32'h0);
    chk("bub_first", {27'd0, w_reg_addr}, 32'd7);
`ifdef WB_RETIRE_CNT_EN
    chk("ret_1", w_retired_obs, 32'd1);
`endif
    step(0, 0, 32'h0000_3104, 5'd5, 2'd0, 3'd0, 32'h0000_0005, 32'h0);
    chk("bub_mid", {27'd0, w_reg_addr}, 32'd0);
    chk("bub_valid", {31'd0, w_valid}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("ret_2", w_retired_obs, 32'd1);
`endif
    step(0, 1, 32'h0000_3108, 5'd6, 2'd0, 3'd0, 32'h0000_0006, 32'h0);
    chk("bub_last", {27'd0, w_reg_addr}, 32'd6);
`ifdef WB_RETIRE_CNT_EN
    chk("ret_3", w_retired_obs, 32'd2);
`endif

    // reset while M holds a write to $9
    step(0, 1, 32'h0000_3200, 5'd3, 2'd0, 3'd0, 32'h0000_0033, 32'h0);
    step(1, 1, 32'h0000_3204, 5'd9, 2'd0, 3'd0, 32'h0000_0099, 32'h0);
    chk("midrst_addr", {27'd0, w_reg_addr}, 32'd0);
    chk("midrst_pc", w_pc, 32'h0000_3000);

    // back-to-back traffic after reset
    for (int i = 0; i < 6; i++)
      step(0, (i % 3) != 1, 32'h0000_3300 + 32'(4 * i), 5'(i + 1), 2'(i % 3), 3'(i % 5),
           32'h0101_0100 * 32'(i + 1) + 32'(i), 32'hF00D_0000 | 32'(i * 257));
    step(0, 0, 32'h0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
